// File: rtl/rv_pkg.sv
// Shared RV32IM core types and constants, including the instruction fetch
// FSM state, fetch buffer entry and fetch helper functions.
package rv_pkg;

  localparam int XLEN            = 32;
  localparam int FETCH_DEPTH_DEF = 2;

  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] PC_STEP       = 32'h0000_0004;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_GAP  = 2'd2,
    FETCH_ERR  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential PC step; wraps naturally at the top of the address space.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/rv_fetch_if.sv
// Fetch unit bus: ROM request/response, decode handshake and redirect.
// fetch_err_o exists only when RV_FETCH_ALIGN_CHECK_EN is defined.
interface rv_fetch_if;
  import rv_pkg::*;

  logic            instr_req_o;
  logic [XLEN-1:0] instr_addr_o;
  logic            instr_rvalid_i;
  logic [XLEN-1:0] instr_rdata_i;
  logic            fetch_valid_o;
  logic [XLEN-1:0] fetch_instr_o;
  logic [XLEN-1:0] fetch_pc_o;
  logic            fetch_ready_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
`ifdef RV_FETCH_ALIGN_CHECK_EN
  logic            fetch_err_o;
`endif

  modport master (
    output instr_req_o, instr_addr_o,
    input  instr_rvalid_i, instr_rdata_i,
    output fetch_valid_o, fetch_instr_o, fetch_pc_o,
    input  fetch_ready_i, redirect_i, redirect_pc_i
`ifdef RV_FETCH_ALIGN_CHECK_EN
    , output fetch_err_o
`endif
  );

  modport slave (
    input  instr_req_o, instr_addr_o,
    output instr_rvalid_i, instr_rdata_i,
    input  fetch_valid_o, fetch_instr_o, fetch_pc_o,
    output fetch_ready_i, redirect_i, redirect_pc_i
`ifdef RV_FETCH_ALIGN_CHECK_EN
    , input fetch_err_o
`endif
  );

endinterface

// File: rtl/rv_fetch_fifo.sv
// Instruction buffer of fetch_entry_t with synchronous flush. Pointers carry
// an extra wrap bit so full and empty are distinguishable.
module rv_fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEF
) (
  input  logic         clk_i,
  input  logic         arstn_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]  count_s;
  logic         push_ok_s, pop_ok_s;
  fetch_entry_t mem_q [DEPTH];

  assign count_s   = wr_q - rd_q;
  assign empty_o   = (count_s == '0);
  assign full_o    = (count_s == DEPTH_C);
  assign count_o   = count_s;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);
  assign head_o    = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok_s) wr_d = wr_q + ONE_C;
      else           wr_d = wr_q;
      if (pop_ok_s)  rd_d = rd_q + ONE_C;
      else           rd_d = rd_q;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_s && !flush_i) mem_q[wr_q[AW-1:0]] <= entry_i;
  end

endmodule

// File: rtl/rv_fetch.sv
// RV32IM instruction fetch: PC, single-outstanding ROM requests, redirects.
// Optional misaligned-redirect trapping via RV_FETCH_ALIGN_CHECK_EN.
module rv_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int              FIFO_DEPTH = FETCH_DEPTH_DEF
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  rv_fetch_if.master  bus
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            push_s, pop_s, flush_s;
  logic            full_s, empty_s;
  logic [AW:0]     count_s;
  fetch_entry_t    entry_s, head_s;

  assign entry_s = '{pc: pc_q, instr: bus.instr_rdata_i};
  // A redirect discards the head, so decode must not see its pop honoured.
  assign pop_s   = !empty_s && bus.fetch_ready_i && !bus.redirect_i;

  rv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .flush_i (flush_s),
    .push_i  (push_s),
    .entry_i (entry_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push_s  = 1'b0;
    flush_s = 1'b0;
    if (bus.redirect_i) begin
      flush_s = 1'b1;
      pc_d    = pc_align(bus.redirect_pc_i);
`ifdef RV_FETCH_ALIGN_CHECK_EN
      if (bus.redirect_pc_i[1:0] != 2'b00) state_d = FETCH_ERR;
      else if (state_q == FETCH_REQ)       state_d = FETCH_GAP;
      else                                 state_d = FETCH_IDLE;
`else
      if (state_q == FETCH_REQ) state_d = FETCH_GAP;
      else                      state_d = FETCH_IDLE;
`endif
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          if (count_s < DEPTH_C) state_d = FETCH_REQ;
          else                   state_d = FETCH_IDLE;
        end
        FETCH_REQ: begin
          if (bus.instr_rvalid_i && !full_s) begin
            push_s  = 1'b1;
            pc_d    = pc_next(pc_q);
            state_d = FETCH_GAP;
          end else begin
            state_d = FETCH_REQ;
          end
        end
        // The ROM needs req low for a cycle to restart its valid delay.
        FETCH_GAP: state_d = FETCH_IDLE;
`ifdef RV_FETCH_ALIGN_CHECK_EN
        FETCH_ERR: state_d = FETCH_ERR;
`endif
        default:   state_d = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= FETCH_IDLE;
      pc_q    <= BOOT_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.instr_req_o   = (state_q == FETCH_REQ);
  assign bus.instr_addr_o  = pc_q;
  assign bus.fetch_valid_o = !empty_s;
  assign bus.fetch_instr_o = head_s.instr;
  assign bus.fetch_pc_o    = head_s.pc;
`ifdef RV_FETCH_ALIGN_CHECK_EN
  assign bus.fetch_err_o   = (state_q == FETCH_ERR);
`endif

endmodule

// File: tb/tb_rv_fetch.sv
// Self-checking bench for rv_fetch: queue-based fetch model, ROM with L=3,
// and directed scenarios with hand-computed timing and address checks.
module tb_rv_fetch;
  import rv_pkg::*;

  localparam int          L     = 3;
  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  rv_fetch_if bus();

  rv_fetch #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'd3 + 32'h0000_0013;
  endfunction

  // ROM: valid on the (L+1)th consecutive cycle of a held request.
  int rom_cnt;
  always @(posedge clk or negedge arstn) begin
    if (!arstn) rom_cnt <= 0;
    else        rom_cnt <= bus.instr_req_o ? rom_cnt + 1 : 0;
  end
  assign bus.instr_rvalid_i = bus.instr_req_o && (rom_cnt == L);
  assign bus.instr_rdata_i  = bus.instr_rvalid_i ? mem_word(bus.instr_addr_o) : 32'hDEAD_BEEF;

  // Behavioural model: buffered entries, next fetch PC, error flag.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t        q[$];
  logic [31:0] mpc;
  bit          gap_exp;
  bit          merr;
  int          cyc;
  logic [31:0] pops[$];

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      q.delete();
      mpc = BOOT; gap_exp = 1'b0; merr = 1'b0; cyc = 0;
    end else begin
      cyc++;
      gap_exp = 1'b0;
      if (bus.redirect_i) begin
        q.delete();
        gap_exp = bus.instr_req_o;
        mpc = bus.redirect_pc_i & 32'hFFFF_FFFC;
`ifdef RV_FETCH_ALIGN_CHECK_EN
        merr = (bus.redirect_pc_i[1:0] != 2'b00);
`endif
      end else begin
        if (q.size() != 0 && bus.fetch_ready_i) begin
          pops.push_back(q[0].pc);
          void'(q.pop_front());
        end
        if (bus.instr_rvalid_i) begin
          q.push_back('{pc: mpc, instr: mem_word(mpc)});
          mpc = mpc + 32'd4;
          gap_exp = 1'b1;
        end
      end
    end
  end

  logic [31:0] rr_addr[$];
  int          rr_cyc[$];
  int          vr_cyc[$];
  logic [31:0] vr_instr[$];
  logic        prev_req = 1'b0, prev_valid = 1'b0;

  // Per-cycle compare against the model, plus edge logging for directed checks.
  always @(negedge clk) begin
    chk("valid", bus.fetch_valid_o, (q.size() != 0));
    if (q.size() != 0) begin
      chk("head_pc", bus.fetch_pc_o, q[0].pc);
      chk("head_instr", bus.fetch_instr_o, q[0].instr);
    end else begin
      chk("empty_pc", bus.fetch_pc_o, 32'h0);
      chk("empty_instr", bus.fetch_instr_o, 32'h0);
    end
    if (bus.instr_req_o) begin
      chk("req_addr", bus.instr_addr_o, mpc);
      chk("req_room", (q.size() < DEPTH), 32'h1);
    end
    if (gap_exp) chk("gap_req_low", bus.instr_req_o, 32'h0);
`ifdef RV_FETCH_ALIGN_CHECK_EN
    chk("err_flag", bus.fetch_err_o, merr);
    if (merr) chk("err_no_req", bus.instr_req_o, 32'h0);
`endif
    if (bus.instr_req_o && !prev_req) begin
      rr_addr.push_back(bus.instr_addr_o);
      rr_cyc.push_back(cyc);
    end
    if (bus.fetch_valid_o && !prev_valid) begin
      vr_cyc.push_back(cyc);
      vr_instr.push_back(bus.fetch_instr_o);
    end
    prev_req   = bus.instr_req_o;
    prev_valid = bus.fetch_valid_o;
  end

  function automatic logic [31:0] rr_a(input int i);
    if (i < rr_addr.size()) return rr_addr[i];
    return 32'h0BAD_0BAD;
  endfunction
  function automatic int rr_c(input int i);
    if (i < rr_cyc.size()) return rr_cyc[i];
    return -1;
  endfunction
  function automatic int vr_c(input int i);
    if (i < vr_cyc.size()) return vr_cyc[i];
    return -1;
  endfunction
  function automatic logic [31:0] vr_i(input int i);
    if (i < vr_instr.size()) return vr_instr[i];
    return 32'h0BAD_0BAD;
  endfunction
  function automatic logic [31:0] pop_at(input int i);
    if (i < pops.size()) return pops[i];
    return 32'h0BAD_0BAD;
  endfunction

  task automatic clear_logs();
    rr_addr.delete(); rr_cyc.delete(); vr_cyc.delete(); vr_instr.delete(); pops.delete();
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    clear_logs();
    repeat (2) @(negedge clk);
    #1 arstn = 1'b1;
  endtask

  task automatic wait_rr(input int n, input int budget, input string nm);
    int i = 0;
    while (rr_addr.size() < n && i < budget) begin @(negedge clk); #1; i++; end
    chk(nm, (rr_addr.size() >= n), 32'h1);
  endtask

  task automatic wait_vr(input int n, input int budget, input string nm);
    int i = 0;
    while (vr_cyc.size() < n && i < budget) begin @(negedge clk); #1; i++; end
    chk(nm, (vr_cyc.size() >= n), 32'h1);
  endtask

  task automatic wait_pops(input int n, input int budget, input string nm);
    int i = 0;
    while (pops.size() < n && i < budget) begin @(negedge clk); #1; i++; end
    chk(nm, (pops.size() >= n), 32'h1);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    bus.redirect_i = 1'b1; bus.redirect_pc_i = pc;
    @(negedge clk); #1;
    bus.redirect_i = 1'b0;
  endtask

  initial begin
    int base, rcyc, nreq;
    bit found;
    bus.fetch_ready_i = 1'b1; bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0;

    // Reset values while held in reset.
    repeat (2) @(negedge clk); #1;
    chk("rst_req", bus.instr_req_o, 32'h0);
    chk("rst_addr", bus.instr_addr_o, BOOT);
    chk("rst_valid", bus.fetch_valid_o, 32'h0);
    chk("rst_pc", bus.fetch_pc_o, 32'h0);
    chk("rst_instr", bus.fetch_instr_o, 32'h0);
`ifdef RV_FETCH_ALIGN_CHECK_EN
    chk("rst_err", bus.fetch_err_o, 32'h0);
`endif

    // Streaming with decode always ready.
    do_reset();
    wait_vr(3, 60, "stream_timeout");
    chk("first_valid_cyc", vr_c(0), 5);
    chk("second_valid_cyc", vr_c(1), 11);
    chk("third_valid_cyc", vr_c(2), 17);
    chk("first_instr", vr_i(0), 32'h0000_0013);
    chk("second_instr", vr_i(1), 32'h0000_001F);
    chk("addr0", rr_a(0), 32'h0);
    chk("addr1", rr_a(1), 32'h4);
    chk("addr2", rr_a(2), 32'h8);
    chk("first_req_cyc", rr_c(0), 1);

    // Decode stalled: buffer fills with PC 0 and 4, then fetch parks.
    bus.fetch_ready_i = 1'b0;
    do_reset();
    repeat (40) @(negedge clk);
    #1;
    chk("stall_valid", bus.fetch_valid_o, 32'h1);
    chk("stall_head_pc", bus.fetch_pc_o, 32'h0);
    chk("stall_nreqs", rr_addr.size(), 32'd2);
    nreq = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); #1; if (bus.instr_req_o) nreq++; end
    chk("stall_req_low", nreq, 32'd0);
    bus.fetch_ready_i = 1'b1;
    wait_pops(3, 80, "drain_timeout");
    chk("drain0", pop_at(0), 32'h0);
    chk("drain1", pop_at(1), 32'h4);
    chk("drain2", pop_at(2), 32'h8);

    // Redirect coinciding with the response for PC 8, PC 4 still buffered.
    bus.fetch_ready_i = 1'b1;
    do_reset();
    wait_vr(1, 30, "redir_first_timeout");
    @(negedge clk); #1;
    bus.fetch_ready_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.instr_rvalid_i && bus.instr_addr_o == 32'h8) found = 1'b1;
      else begin @(negedge clk); #1; end
    end
    chk("redir_found_rsp8", found, 32'h1);
    base = rr_addr.size();
    pulse_redirect(32'h0000_0040);
    rcyc = cyc;
    chk("redir_flushed", bus.fetch_valid_o, 32'h0);
    chk("redir_pops", pops.size(), 32'd1);
    wait_rr(base + 1, 20, "redir_req_timeout");
    chk("redir_addr", rr_a(base), 32'h40);
    chk("redir_latency", rr_c(base) - rcyc, 32'd2);
    bus.fetch_ready_i = 1'b1;

    // Redirect to the last word: sequential fetch wraps to 0.
    base = rr_addr.size();
    pulse_redirect(32'hFFFF_FFFC);
    wait_rr(base + 2, 40, "wrap_timeout");
    chk("wrap_addr0", rr_a(base), 32'hFFFF_FFFC);
    chk("wrap_addr1", rr_a(base + 1), 32'h0);

    // Misaligned redirect.
    base = rr_addr.size();
    pulse_redirect(32'h0000_0042);
`ifdef RV_FETCH_ALIGN_CHECK_EN
    chk("mis_err_set", bus.fetch_err_o, 32'h1);
    nreq = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); #1; if (bus.instr_req_o) nreq++; end
    chk("mis_no_req", nreq, 32'd0);
    chk("mis_empty", bus.fetch_valid_o, 32'h0);
    base = rr_addr.size();
    pulse_redirect(32'h0000_0080);
    chk("mis_err_clr", bus.fetch_err_o, 32'h0);
    wait_rr(base + 1, 20, "mis_resume_timeout");
    chk("mis_resume_addr", rr_a(base), 32'h80);
`else
    wait_rr(base + 1, 20, "mis_timeout");
    chk("mis_aligned_addr", rr_a(base), 32'h40);
`endif

    // Asynchronous reset with a request held and one entry buffered.
    bus.fetch_ready_i = 1'b0;
    do_reset();
    wait_rr(2, 30, "arst_setup_timeout");
    chk("arst_pre_valid", bus.fetch_valid_o, 32'h1);
    chk("arst_pre_req", bus.instr_req_o, 32'h1);
    #1 arstn = 1'b0;
    #1;
    chk("arst_req", bus.instr_req_o, 32'h0);
    chk("arst_addr", bus.instr_addr_o, BOOT);
    chk("arst_valid", bus.fetch_valid_o, 32'h0);
    chk("arst_pc", bus.fetch_pc_o, 32'h0);
    chk("arst_instr", bus.fetch_instr_o, 32'h0);
    clear_logs();
    @(negedge clk); #1;
    arstn = 1'b1;
    bus.fetch_ready_i = 1'b1;
    wait_rr(1, 20, "arst_restart_timeout");
    chk("arst_restart_addr", rr_a(0), BOOT);
    chk("arst_restart_cyc", rr_c(0), 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
